// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: load-use and branch-operand stalls, bubble and taken-branch flush.
// Optional macro HAZARD_STATS_EN adds saturating stall-cycle and flush counters.
module hazard_stall_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op_ID,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic [5:0] op_EXE,
  input  logic [4:0] num_write_EXE,
  input  logic       reg_write_EXE,
  input  logic [5:0] op_MEM,
  input  logic [4:0] num_write_MEM,
  input  logic       reg_write_MEM,
  input  logic       branch_taken_ID,
  output logic       pc_write_en,
  output logic       if_id_write_en,
  output logic       id_exe_bubble,
  output logic       if_id_flush,
  output logic       stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t     state;
  logic [1:0] cnt;
  logic       is_beq, uses_rs, uses_rt, match_e, match_m;
  logic [1:0] need;

  // Register 0 is hardwired, so a zero source never creates a dependency.
  assign is_beq  = (op_ID == OP_BEQ);
  assign uses_rs = (rs_ID != 5'd0) && (op_ID[5:1] != 5'b00001);
  assign uses_rt = (rt_ID != 5'd0) &&
                   ((op_ID == OP_RTYPE) || (op_ID == OP_SW) || (op_ID == OP_BEQ));
  assign match_e = reg_write_EXE &&
                   ((uses_rs && (rs_ID == num_write_EXE)) || (uses_rt && (rt_ID == num_write_EXE)));
  assign match_m = reg_write_MEM &&
                   ((uses_rs && (rs_ID == num_write_MEM)) || (uses_rt && (rt_ID == num_write_MEM)));

  always_comb begin
    need = 2'd0;
    if (is_beq) begin
      if (match_e)
        need = (op_EXE == OP_LW) ? 2'd2 : 2'd1;
      else if (match_m && (op_MEM == OP_LW))
        need = 2'd1;
    end else if (match_e && (op_EXE == OP_LW)) begin
      need = 2'd1;
    end
  end

  // Gating with rst_n keeps the outputs at their idle values while reset is held.
  assign stall          = rst_n & ((state == HOLD) | (need != 2'd0));
  assign pc_write_en    = ~stall;
  assign if_id_write_en = ~stall;
  assign id_exe_bubble  = stall;
  assign if_id_flush    = rst_n & branch_taken_ID & ~stall & is_beq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (need == 2'd2) begin
            state <= HOLD;
            cnt   <= 2'd1;
          end
        end
        HOLD: begin
          if (cnt <= 2'd1) begin
            cnt   <= 2'd0;
            state <= RUN;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
      flush_count  <= 16'd0;
    end else begin
      if (stall && !(&stall_cycles))
        stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush && !(&flush_count))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: expected output vectors are queued as stimulus is driven
// and popped when the outputs are sampled on the falling edge.
module tb_hazard_stall_ctrl;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BQ = 6'b000100, JP = 6'b000010;
  // {pc_write_en, if_id_write_en, id_exe_bubble, if_id_flush, stall}
  localparam logic [4:0] RUNV = 5'b11000, STL = 5'b00101, FLS = 5'b11010;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [5:0] op_ID = '0, op_EXE = '0, op_MEM = '0;
  logic [4:0] rs_ID = '0, rt_ID = '0, num_write_EXE = '0, num_write_MEM = '0;
  logic       reg_write_EXE = 1'b0, reg_write_MEM = 1'b0, branch_taken_ID = 1'b0;
  logic       pc_write_en, if_id_write_en, id_exe_bubble, if_id_flush, stall;

  exp_t q[$];
  int   tests = 0, fails = 0;
  int   m_stalls = 0, m_flushes = 0;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  hazard_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .op_ID(op_ID), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .op_EXE(op_EXE), .num_write_EXE(num_write_EXE), .reg_write_EXE(reg_write_EXE),
    .op_MEM(op_MEM), .num_write_MEM(num_write_MEM), .reg_write_MEM(reg_write_MEM),
    .branch_taken_ID(branch_taken_ID),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .id_exe_bubble(id_exe_bubble), .if_id_flush(if_id_flush), .stall(stall)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [5:0] oi, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [5:0] oe, input logic [4:0] we, input logic rwe,
                        input logic [5:0] om, input logic [4:0] wm, input logic rwm,
                        input logic bt);
    op_ID = oi; rs_ID = rs; rt_ID = rt;
    op_EXE = oe; num_write_EXE = we; reg_write_EXE = rwe;
    op_MEM = om; num_write_MEM = wm; reg_write_MEM = rwm;
    branch_taken_ID = bt;
  endtask

  task automatic push(input string tag, input logic [4:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [4:0] obs;
    obs = {pc_write_en, if_id_write_en, id_exe_bubble, if_id_flush, stall};
    tests++;
    if (q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %b, required an expected entry", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock cycle: inputs already applied, expectation queued, sampled on the falling edge.
  task automatic cyc(input string tag, input logic [4:0] exp);
    push(tag, exp);
    if (exp[4:0] == STL) m_stalls++;
    if (exp[4:0] == FLS) m_flushes++;
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef HAZARD_STATS_EN
    tests++;
    assert (stall_cycles === 32'(m_stalls)) else begin
      fails++;
      $error("FAIL %s_stall_cycles: observed %0d expected %0d", tag, stall_cycles, m_stalls);
    end
    tests++;
    assert (flush_count === 16'(m_flushes)) else begin
      fails++;
      $error("FAIL %s_flush_count: observed %0d expected %0d", tag, flush_count, m_flushes);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    #2;
    push("reset_outputs", RUNV);
    check();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // load-use: one stall, released once the load reaches MEM
    set_in(RT, 5'd8, 5'd0, LW, 5'd8, 1'b1, RT, 5'd0, 1'b0, 1'b0); cyc("lu_stall", STL);
    set_in(RT, 5'd8, 5'd0, RT, 5'd0, 1'b0, LW, 5'd8, 1'b1, 1'b0); cyc("lu_release", RUNV);

    // load then branch: RUN stall, HOLD stall (hazard-free inputs, taken ignored), then RUN
    set_in(BQ, 5'd1, 5'd9, LW, 5'd9, 1'b1, RT, 5'd0, 1'b0, 1'b0); cyc("lb_run", STL);
    set_in(BQ, 5'd1, 5'd9, RT, 5'd0, 1'b0, RT, 5'd0, 1'b0, 1'b1); cyc("lb_hold", STL);
    set_in(BQ, 5'd1, 5'd9, RT, 5'd0, 1'b0, RT, 5'd0, 1'b0, 1'b0); cyc("lb_done", RUNV);

    // ALU then branch, taken asserted while stalled: no flush
    set_in(BQ, 5'd5, 5'd0, RT, 5'd5, 1'b1, RT, 5'd0, 1'b0, 1'b1); cyc("ab_stall_noflush", STL);
    set_in(BQ, 5'd5, 5'd0, RT, 5'd0, 1'b0, RT, 5'd5, 1'b1, 1'b0); cyc("ab_release", RUNV);
    set_in(BQ, 5'd5, 5'd0, RT, 5'd0, 1'b1, RT, 5'd0, 1'b0, 1'b0); cyc("ab_rd0", RUNV);
    set_in(BQ, 5'd0, 5'd0, RT, 5'd0, 1'b1, RT, 5'd0, 1'b0, 1'b0); cyc("r0_nomatch", RUNV);

    // taken branch with no hazard: single flush cycle
    set_in(BQ, 5'd1, 5'd2, RT, 5'd3, 1'b1, RT, 5'd0, 1'b0, 1'b1); cyc("flush", FLS);
    set_in(RT, 5'd0, 5'd0, RT, 5'd0, 1'b0, RT, 5'd0, 1'b0, 1'b0); cyc("flush_one", RUNV);

    // remaining N rules and source-usage rules
    set_in(BQ, 5'd7, 5'd0, RT, 5'd0, 1'b0, LW, 5'd7, 1'b1, 1'b0); cyc("beq_mem_lw", STL);
    set_in(BQ, 5'd7, 5'd0, RT, 5'd0, 1'b0, RT, 5'd7, 1'b1, 1'b0); cyc("beq_mem_alu", RUNV);
    set_in(SW, 5'd1, 5'd6, LW, 5'd6, 1'b1, RT, 5'd0, 1'b0, 1'b0); cyc("sw_rt", STL);
    set_in(LW, 5'd1, 5'd6, LW, 5'd6, 1'b1, RT, 5'd0, 1'b0, 1'b0); cyc("lw_rt_unused", RUNV);
    set_in(JP, 5'd6, 5'd6, LW, 5'd6, 1'b1, RT, 5'd0, 1'b0, 1'b0); cyc("j_no_rs", RUNV);
    set_in(RT, 5'd6, 5'd0, LW, 5'd6, 1'b0, RT, 5'd0, 1'b0, 1'b0); cyc("no_regwrite", RUNV);
    set_in(RT, 5'd6, 5'd0, RT, 5'd6, 1'b1, RT, 5'd0, 1'b0, 1'b0); cyc("alu_fwd", RUNV);
    set_in(RT, 5'd1, 5'd2, RT, 5'd0, 1'b0, RT, 5'd0, 1'b0, 1'b1); cyc("flush_nonbeq", RUNV);
    check_stats("stats");

    // reset asserted during HOLD takes effect immediately
    set_in(BQ, 5'd1, 5'd9, LW, 5'd9, 1'b1, RT, 5'd0, 1'b0, 1'b0); cyc("rh_run", STL);
    rst_n = 1'b0;
    m_stalls = 0;
    m_flushes = 0;
    #1;
    push("rh_reset_async", RUNV);
    check();
    check_stats("rh_reset");
    #2 rst_n = 1'b1;
    set_in(BQ, 5'd1, 5'd2, RT, 5'd0, 1'b0, RT, 5'd0, 1'b0, 1'b0); cyc("rh_after", RUNV);

    // a fresh two-cycle hold after reset shows state and counter restarted cleanly
    set_in(BQ, 5'd1, 5'd9, LW, 5'd9, 1'b1, RT, 5'd0, 1'b0, 1'b0); cyc("rh2_run", STL);
    set_in(BQ, 5'd1, 5'd9, RT, 5'd0, 1'b0, RT, 5'd0, 1'b0, 1'b0); cyc("rh2_hold", STL);
    set_in(BQ, 5'd1, 5'd9, RT, 5'd0, 1'b0, RT, 5'd0, 1'b0, 1'b1); cyc("rh2_flush", FLS);
    set_in(RT, 5'd0, 5'd0, RT, 5'd0, 1'b0, RT, 5'd0, 1'b0, 1'b0); cyc("rh2_idle", RUNV);
    check_stats("stats_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
